pipe_stage_reg: RTL and testbench
=================================

Name: pipe_stage_reg

Overview:
Parametrised pipeline stage register with a valid/ready handshake and a two-entry skid buffer. It supersedes the fixed-width enable/clear flops between processor pipeline stages. Stall becomes back-pressure (out_ready low), and clear becomes flush. A saturating stall-cycle counter is added for performance monitoring. It is instantiated between IF/ID, ID/EX, EX/MEM and MEM/WB.

Parameters:
WIDTH, `WORD_SIZE, payload width in bits (legal range 1..256).
RESET_VAL, '0, value loaded into both payload registers on rst or flush (WIDTH bits).
CNT_W, 16, width of the stall-cycle counter.

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous, active-high reset
flush  in  1  synchronous discard of all held entries
in_valid  in  1  upstream has data
in_ready  out  1  stage can accept; registered, depends only on state
in_data  in  WIDTH  upstream payload
out_valid  out  1  stage holds data for downstream
out_ready  in  1  downstream accepts
out_data  out  WIDTH  payload from main register
occupancy  out  2  entries held (0, 1 or 2)
stall_cycles  out  CNT_W  saturating count of cycles with out_valid=1 and out_ready=0

Behaviour:
- Handshake definitions:
  - in_fire = in_valid & in_ready
  - out_fire = out_valid & out_ready
  - A transfer occurs on the rising edge where fire=1.
- State machine (state enum):
  - EMPTY: in_ready=1, out_valid=0.
  - ONE: in_ready=1, out_valid=1.
  - FULL: in_ready=0, out_valid=1.
- Transitions, evaluated when rst=0 and flush=0:
  - EMPTY: in_fire -> ONE, main<=in_data. Otherwise stay EMPTY.
  - ONE:
    - in_fire & out_fire -> ONE, main<=in_data.
    - in_fire only -> FULL, skid<=in_data, main unchanged.
    - out_fire only -> EMPTY.
    - neither -> ONE.
  - FULL: out_fire -> ONE, main<=skid. Otherwise stay FULL. in_data is ignored in FULL.
- Derived outputs:
  - out_data = main register (combinational from the register).
  - out_data holds its last value while EMPTY; consumers qualify it with out_valid.
  - occupancy: EMPTY=0, ONE=1, FULL=2.
- Latency and throughput:
  - Data accepted at edge N is visible on out_data after edge N when the stage was EMPTY, or ONE with a simultaneous out_fire.
  - Sustained throughput is 1 transfer/cycle when out_ready=1 continuously.
- Ordering: strict FIFO; the skid entry is never presented before main.
- Reset (rst=1 at an edge):
  - state<=EMPTY, main<=RESET_VAL, skid<=RESET_VAL, stall_cycles<=0.
  - After reset: in_ready=1, out_valid=0, occupancy=0.
  - rst has priority over flush and over any handshake. Reset mid-transfer drops all data.
- Flush (flush=1, rst=0):
  - state<=EMPTY, main and skid <= RESET_VAL.
  - An in_fire or out_fire in the same cycle is discarded: upstream sees in_ready=1 but the data is lost, by design.
  - stall_cycles is NOT cleared by flush.
- stall_cycles:
  - Increments by 1 each edge where out_valid=1 and out_ready=0.
  - Saturates at 2^CNT_W-1; no wrap-around.
  - Cleared only by rst.
  - Counts stall cycles in the flush cycle too (pre-flush state).
- Invariant checks:
  - Assert that in_valid is not dropped while in_ready=0; upstream must hold in_data stable.
  - Assert that state never encodes an illegal value.

Decomposition:
- Shared package pipe_pkg holds:
  - typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_FULL} pipe_state_t
  - occupancy encoding constants
- WORD_SIZE remains in definitions.sv.
- One natural sub-module: sat_counter (parametric width, synchronous clear, enable, saturate), reused for other performance counters.
- The payload registers are inline; no separate flop instances.

Test Plan:
1. Reset then single transfer: rst=1 for 2 cycles; then in_valid=1, in_data=0xDEADBEEF, out_ready=1 -> next cycle out_valid=1, out_data=0xDEADBEEF, occupancy=1; following cycle with in_valid=0 -> out_valid=0.
2. Back-pressure fill: out_ready=0; push 0x11 then 0x22 -> occupancy=2, in_ready=0. A third push of 0x33 is not accepted. Raise out_ready -> outputs 0x11, 0x22 in order, then empty; 0x33 is accepted only once in_ready returns to 1.
3. Streaming: out_ready=1, in_valid=1 for 100 cycles with an incrementing payload -> 100 outputs in order, occupancy never 2, stall_cycles=0.
4. Flush while FULL: stage holds 0xA, 0xB; assert flush with in_valid=1, in_data=0xC -> next cycle out_valid=0, occupancy=0, out_data=RESET_VAL, 0xC never appears; stall_cycles retains its prior count.
5. Counter saturation (CNT_W=4): hold out_valid=1, out_ready=0 for 20 cycles -> stall_cycles reads 15 and stays there. rst -> 0. A subsequent flush leaves a nonzero count unchanged.
6. Reset priority: rst=1 and flush=1 in the same cycle while in ONE with out_ready=1 -> EMPTY, no out_fire consumed downstream, stall_cycles=0; WIDTH=8 and WIDTH=64 builds pass scenarios 1–4.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage register.
//   pipe_state_t : stage fill state (EMPTY / ONE / FULL)
//   OCC_*        : occupancy encodings driven on the occupancy port
//   occ_of()     : maps a stage state to its occupancy encoding
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } pipe_state_t;

  localparam logic [1:0] OCC_EMPTY = 2'd0;
  localparam logic [1:0] OCC_ONE   = 2'd1;
  localparam logic [1:0] OCC_FULL  = 2'd2;

  function automatic logic [1:0] occ_of(input pipe_state_t s);
    logic [1:0] occ;
    occ = OCC_EMPTY;
    case (s)
      ST_ONE:  occ = OCC_ONE;
      ST_FULL: occ = OCC_FULL;
      default: occ = OCC_EMPTY;
    endcase
    return occ;
  endfunction

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating up-counter, reusable for performance monitoring.
//   clk : rising-edge clock
//   clr : synchronous clear, has priority over en
//   en  : count enable; increments by one per enabled edge
//   cnt : current count, sticks at all-ones (never wraps)
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt
);

  localparam logic [W-1:0] INC = W'(1);

  always_ff @(posedge clk) begin
    if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != '1)) begin
      cnt <= cnt + INC;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with a valid/ready handshake and a two-entry skid
// buffer (main + skid), plus a saturating stall-cycle counter.
//
// Handshake: a transfer happens on a rising edge where valid & ready are both
// high on that side. in_ready and out_valid are decoded from the state
// register only, so neither depends combinationally on any input. While
// in_ready is low, upstream must keep in_valid high and in_data stable.
//
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   flush               : synchronous discard of all held entries
//   in_valid/in_ready   : upstream handshake, in_data payload
//   out_valid/out_ready : downstream handshake, out_data = main register
//   occupancy           : entries held (0, 1, 2); also exposes the FSM state
//   stall_cycles        : saturating count of out_valid & !out_ready edges
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif

module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int               WIDTH     = `WORD_SIZE,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int               CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] stall_cycles
);

  pipe_state_t      state, state_n;
  logic [WIDTH-1:0] main_q, main_n;
  logic [WIDTH-1:0] skid_q, skid_n;
  logic             in_fire, out_fire;

  assign in_ready  = (state != ST_FULL);
  assign out_valid = (state != ST_EMPTY);
  assign out_data  = main_q;
  assign occupancy = occ_of(state);

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  always_comb begin
    state_n = state;
    main_n  = main_q;
    skid_n  = skid_q;
    case (state)
      ST_EMPTY: begin
        if (in_fire) begin
          state_n = ST_ONE;
          main_n  = in_data;
        end
      end
      ST_ONE: begin
        if (in_fire && out_fire) begin
          main_n = in_data;
        end else if (in_fire) begin
          // Downstream stalled: park the new word behind main.
          state_n = ST_FULL;
          skid_n  = in_data;
        end else if (out_fire) begin
          state_n = ST_EMPTY;
        end
      end
      ST_FULL: begin
        // in_ready is low here, so in_data is never captured.
        if (out_fire) begin
          state_n = ST_ONE;
          main_n  = skid_q;
        end
      end
      default: state_n = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state  <= ST_EMPTY;
      main_q <= RESET_VAL;
      skid_q <= RESET_VAL;
    end else begin
      state  <= state_n;
      main_q <= main_n;
      skid_q <= skid_n;
    end
  end

  // Only rst clears the counter; the flush cycle still counts a stall seen
  // in the pre-flush state.
  sat_counter #(
    .W (CNT_W)
  ) u_stall_cnt (
    .clk (clk),
    .clr (rst),
    .en  (out_valid & ~out_ready),
    .cnt (stall_cycles)
  );

  a_in_hold: assert property (@(posedge clk) disable iff (rst || flush)
    (in_valid && !in_ready) |=> (in_valid && $stable(in_data)));

  a_state_legal: assert property (@(posedge clk) disable iff (rst)
    (state inside {ST_EMPTY, ST_ONE, ST_FULL}));

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: reset, single transfer, back-pressure,
// streaming, flush, counter saturation and reset priority.
module tb_pipe_stage_reg;

  localparam int               WIDTH     = 32;
  localparam int               CNT_W     = 4;
  localparam logic [WIDTH-1:0] RESET_VAL = 32'h5A5A_0000;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_data = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       occupancy;
  logic [CNT_W-1:0] stall_cycles;

  int n_checks = 0;
  int n_errors = 0;
  logic [WIDTH-1:0] exp_q[$];

  pipe_stage_reg #(
    .WIDTH     (WIDTH),
    .RESET_VAL (RESET_VAL),
    .CNT_W     (CNT_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .occupancy    (occupancy),
    .stall_cycles (stall_cycles)
  );

  // Clock
  always #5 clk = ~clk;

  // Advance one edge; inputs change and outputs are sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    // Reset held for two edges
    rst = 1'b1;
    step();
    step();
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_occ", occupancy, 0);
    check("rst_data", out_data, RESET_VAL);
    check("rst_stall", stall_cycles, 0);
    rst = 1'b0;

    // 1. Single transfer
    in_valid = 1'b1; in_data = 32'hDEADBEEF; out_ready = 1'b1;
    step();
    check("t1_valid", out_valid, 1);
    check("t1_data", out_data, 32'hDEADBEEF);
    check("t1_occ", occupancy, 1);
    in_valid = 1'b0;
    step();
    check("t1_drain_valid", out_valid, 0);
    check("t1_drain_occ", occupancy, 0);
    check("t1_hold_data", out_data, 32'hDEADBEEF);
    check("t1_stall", stall_cycles, 0);

    // 2. Back-pressure fill
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'h11;
    step();
    check("t2_occ1", occupancy, 1);
    check("t2_data11", out_data, 32'h11);
    check("t2_stall0", stall_cycles, 0);
    in_data = 32'h22;
    step();
    check("t2_occ2", occupancy, 2);
    check("t2_ready0", in_ready, 0);
    check("t2_head11", out_data, 32'h11);
    check("t2_stall1", stall_cycles, 1);
    in_data = 32'h33;
    step();
    check("t2_occ_still2", occupancy, 2);
    check("t2_head_still11", out_data, 32'h11);
    check("t2_stall2", stall_cycles, 2);
    step();
    check("t2_stall3", stall_cycles, 3);
    out_ready = 1'b1;
    step();
    check("t2_data22", out_data, 32'h22);
    check("t2_occ_after_pop", occupancy, 1);
    check("t2_ready_back", in_ready, 1);
    check("t2_stall_held", stall_cycles, 3);
    step();
    check("t2_data33", out_data, 32'h33);
    check("t2_occ33", occupancy, 1);
    in_valid = 1'b0;
    step();
    check("t2_empty_valid", out_valid, 0);
    check("t2_empty_occ", occupancy, 0);
    check("t2_stall_final", stall_cycles, 3);

    do_reset();
    check("t2_rst_stall", stall_cycles, 0);

    // 3. Streaming at one transfer per cycle
    out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      in_valid = 1'b1;
      in_data  = 32'h1000 + i;
      exp_q.push_back(32'h1000 + i);
      step();
      check("t3_occ", occupancy, 1);
      check("t3_ready", in_ready, 1);
      check("t3_data", out_data, exp_q.pop_front());
    end
    in_valid = 1'b0;
    step();
    check("t3_drained", out_valid, 0);
    check("t3_q_empty", exp_q.size(), 0);
    check("t3_stall", stall_cycles, 0);

    // 4. Flush while FULL
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'hA;
    step();
    in_data = 32'hB;
    step();
    check("t4_full", occupancy, 2);
    check("t4_stall_pre", stall_cycles, 1);
    flush = 1'b1; in_data = 32'hC;
    step();
    check("t4_valid", out_valid, 0);
    check("t4_occ", occupancy, 0);
    check("t4_data_rst", out_data, RESET_VAL);
    check("t4_ready", in_ready, 1);
    check("t4_stall_kept", stall_cycles, 2);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t4_no_c", out_valid, 0);
      check("t4_no_c_data", out_data, RESET_VAL);
    end

    // 5. Counter saturation (CNT_W = 4)
    do_reset();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'h1;
    step();
    in_valid = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (k == 14) check("t5_cnt14", stall_cycles, 14);
      if (k == 15) check("t5_cnt15", stall_cycles, 15);
    end
    check("t5_sat", stall_cycles, 15);
    check("t5_still_held", out_data, 32'h1);
    do_reset();
    check("t5_rst_clear", stall_cycles, 0);
    in_valid = 1'b1; in_data = 32'h2;
    step();
    in_valid = 1'b0;
    step(); step(); step();
    check("t5_cnt3", stall_cycles, 3);
    out_ready = 1'b1; flush = 1'b1;
    step();
    flush = 1'b0;
    check("t5_flush_keeps", stall_cycles, 3);
    check("t5_flush_occ", occupancy, 0);

    // 6. Reset has priority over flush and handshake
    do_reset();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'h77;
    step();
    in_valid = 1'b0;
    step(); step();
    check("t6_stall2", stall_cycles, 2);
    check("t6_occ1", occupancy, 1);
    out_ready = 1'b1; rst = 1'b1; flush = 1'b1;
    step();
    rst = 1'b0; flush = 1'b0;
    check("t6_occ", occupancy, 0);
    check("t6_valid", out_valid, 0);
    check("t6_stall", stall_cycles, 0);
    check("t6_data", out_data, RESET_VAL);
    check("t6_ready", in_ready, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
